// File: rtl/mha_pkg.sv
// mha_pkg: shared FSM encoding and width constants for the softmax row driver.
package mha_pkg;
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_LOAD = 4'b0010,
    S_RUN  = 4'b0100,
    S_GAP  = 4'b1000
  } sm_state_t;
  localparam int IDX_W   = 8;
  localparam int DEF_D_W = 16;
  localparam int DEF_NUM = 16;
endpackage

// File: rtl/sm_row_fifo.sv
// sm_row_fifo: row FIFO, W bits wide, DEPTH entries (power of two), combinational read of head.
// Ports: clk, rst (sync, active-high), i_push/i_wdata write, i_pop/o_rdata read head, o_full, o_empty.
module sm_row_fifo #(
  parameter int W     = 256,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  assign o_rdata = r_mem[r_rd];
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_wdata;
  end
endmodule

// File: rtl/softmax_row_driver.sv
// softmax_row_driver: buffers score rows, drives the softmax engine with held start/data, returns indexed probability rows.
// Ports: I_CLK/I_RST (sync, active-high); I_ROW_* / O_ROW_RDY score-row input handshake;
//   O_SM_START/O_SM_DATA engine request, I_SM_VLD/I_SM_DATA engine done strobe;
//   O_PROB_* / I_PROB_RDY result handshake with row index; O_BUSY activity; O_ERR sticky watchdog error.
// Define SOFTMAX_WDOG_EN to enable the TIMEOUT-cycle watchdog in S_RUN (otherwise O_ERR is tied 0).
module softmax_row_driver import mha_pkg::*; #(
  parameter int D_W     = DEF_D_W,
  parameter int NUM     = DEF_NUM,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               I_CLK,
  input  logic               I_RST,
  input  logic               I_ROW_VLD,
  output logic               O_ROW_RDY,
  input  logic [D_W*NUM-1:0] I_ROW_DATA,
  output logic               O_SM_START,
  output logic [D_W*NUM-1:0] O_SM_DATA,
  input  logic               I_SM_VLD,
  input  logic [D_W*NUM-1:0] I_SM_DATA,
  output logic               O_PROB_VLD,
  input  logic               I_PROB_RDY,
  output logic [D_W*NUM-1:0] O_PROB_DATA,
  output logic [IDX_W-1:0]   O_PROB_IDX,
  output logic               O_BUSY,
  output logic               O_ERR
);
  localparam int W = D_W * NUM;
  logic             w_full;
  logic             w_empty;
  logic             w_tout;
  logic [W-1:0]     w_head;
  sm_state_t        r_state;
  logic             r_gap;
  logic [W-1:0]     r_hold;
  logic [W-1:0]     r_pdata;
  logic             r_pvld;
  logic [IDX_W-1:0] r_pidx;
  logic [IDX_W-1:0] r_seq;
  sm_row_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (I_CLK),
    .rst     (I_RST),
    .i_push  (I_ROW_VLD && !w_full),
    .i_wdata (I_ROW_DATA),
    .i_pop   (r_state == S_LOAD),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
`ifdef SOFTMAX_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wdog;
  logic            r_err;
  assign w_tout = r_wdog == WD_W'(TIMEOUT - 1);
  assign O_ERR  = r_err;
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wdog <= (r_state == S_RUN && !I_SM_VLD) ? r_wdog + WD_W'(1) : '0;
      if (r_state == S_RUN && !I_SM_VLD && w_tout) r_err <= 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = TIMEOUT[0];
  assign w_tout = 1'b0;
  assign O_ERR  = 1'b0;
`endif
  assign O_ROW_RDY   = !w_full;
  assign O_SM_START  = r_state == S_RUN;
  assign O_SM_DATA   = r_hold;
  assign O_PROB_VLD  = r_pvld;
  assign O_PROB_DATA = r_pdata;
  assign O_PROB_IDX  = r_pidx;
  assign O_BUSY      = r_state != S_IDLE || !w_empty;
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_state <= S_IDLE;
      r_gap   <= 1'b0;
      r_hold  <= '0;
      r_pdata <= '0;
      r_pvld  <= 1'b0;
      r_pidx  <= '0;
      r_seq   <= '0;
    end else begin
      if (r_pvld && I_PROB_RDY) begin
        r_pvld  <= 1'b0;
        r_pdata <= '0;
        r_pidx  <= '0;
      end
      case (r_state)
        S_IDLE: if (!w_empty && !r_pvld) r_state <= S_LOAD;
        S_LOAD: begin
          r_hold  <= w_head;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (I_SM_VLD) begin
            r_pdata <= I_SM_DATA;
            r_pvld  <= 1'b1;
            r_pidx  <= r_seq;
            r_seq   <= r_seq + IDX_W'(1);
            r_state <= S_GAP;
          end else if (w_tout) begin
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          // r_gap toggles 0->1->0, so it is always 0 again on the next entry
          r_gap <= !r_gap;
          if (r_gap) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_row_driver.sv
// tb_softmax_row_driver: directed self-checking bench with a behavioural softmax engine and result scoreboard.
module tb_softmax_row_driver;
  localparam int D_W = 16, NUM = 16, W = D_W * NUM, DEPTH = 4, TIMEOUT = 64;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         row_vld = 1'b0;
  logic         row_rdy;
  logic [W-1:0] row_data = '0;
  logic         sm_start;
  logic [W-1:0] sm_data;
  logic         sm_vld;
  logic [W-1:0] sm_res = '0;
  logic         prob_vld;
  logic         prob_rdy = 1'b1;
  logic [W-1:0] prob_data;
  logic [7:0]   prob_idx;
  logic         busy;
  logic         err;
  logic         eng_vld = 1'b0;
  logic         late_vld = 1'b0;
  bit           eng_on = 1'b1;
  int           eng_lat = 40;
  int           ecnt = 0;
  int           n_chk = 0, n_err = 0, n_out = 0;
  logic [7:0]   exp_idx = '0, last_idx = '0;
  logic [W-1:0] q_in[$], q_out[$];
  logic         prev_start = 1'b0;
  logic [W-1:0] prev_data = '0;
  assign sm_vld = eng_vld | late_vld;
  softmax_row_driver #(.D_W(D_W), .NUM(NUM), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .I_CLK(clk), .I_RST(rst), .I_ROW_VLD(row_vld), .O_ROW_RDY(row_rdy), .I_ROW_DATA(row_data),
    .O_SM_START(sm_start), .O_SM_DATA(sm_data), .I_SM_VLD(sm_vld), .I_SM_DATA(sm_res),
    .O_PROB_VLD(prob_vld), .I_PROB_RDY(prob_rdy), .O_PROB_DATA(prob_data), .O_PROB_IDX(prob_idx),
    .O_BUSY(busy), .O_ERR(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] xf(input logic [W-1:0] r);
    logic [W-1:0] o;
    for (int k = 0; k < NUM; k++) o[D_W*k +: D_W] = r[D_W*k +: D_W] >> 4;
    return o;
  endfunction
  function automatic logic [W-1:0] mk_row(input int s);
    logic [W-1:0] o;
    for (int k = 0; k < NUM; k++) o[D_W*k +: D_W] = D_W'(s * 256 + k * 16);
    return o;
  endfunction
  // behavioural engine: done pulse eng_lat cycles after start rises, aborts when start drops
  initial forever begin
    @(negedge clk);
    if (eng_on && sm_start) begin
      ecnt++;
      if (ecnt == eng_lat) begin
        eng_vld = 1'b1;
        sm_res  = xf(sm_data);
        ecnt    = 0;
      end else eng_vld = 1'b0;
    end else begin
      ecnt    = 0;
      eng_vld = 1'b0;
    end
  end
  // scoreboard: launched row matches pushed row, held stable, results in order with index
  always @(negedge clk) begin
    if (!rst) begin
      if (sm_start && !prev_start) begin
        if (q_in.size() == 0) chk("sm_unexpected", 1, 0);
        else begin
          chk("sm_data", sm_data, q_in[0]);
          q_out.push_back(xf(q_in.pop_front()));
        end
      end
      if (sm_start && prev_start) chk("sm_stable", sm_data, prev_data);
      if (prob_vld && prob_rdy) begin
        if (q_out.size() == 0) chk("prob_unexpected", 1, 0);
        else begin
          chk("prob_data", prob_data, q_out.pop_front());
          chk("prob_idx", prob_idx, exp_idx);
          last_idx = prob_idx;
          exp_idx++;
          n_out++;
        end
      end
    end
    prev_start = sm_start;
    prev_data  = sm_data;
  end
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    row_vld = 1'b0;
    prob_rdy = 1'b1;
    repeat (2) @(negedge clk);
    q_in.delete();
    q_out.delete();
    exp_idx = '0;
    n_out = 0;
    rst = 1'b0;
  endtask
  task automatic push_row(input logic [W-1:0] row);
    int n = 0;
    @(negedge clk);
    row_vld = 1'b1;
    row_data = row;
    while (!row_rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("push_timeout", 0, 1);
    else begin
      @(posedge clk);
      q_in.push_back(row);
    end
    #1 row_vld = 1'b0;
  endtask
  task automatic wait_out(input string tag, input int n, input int lim);
    int c = 0;
    while (n_out < n && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk(tag, n_out, n);
  endtask
  task automatic wait_sig(input string tag, input bit want_vld, input int lim);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(want_vld ? prob_vld : sm_start) && c < lim);
    chk(tag, c < lim, 1);
  endtask
  initial begin
    logic [W-1:0] r0, pd;
    logic [7:0]   pi;
    int           bad, starts;
    do_reset();
    chk("rst_row_rdy", row_rdy, 1);
    chk("rst_sm_start", sm_start, 0);
    chk("rst_sm_data", sm_data, 0);
    chk("rst_prob_vld", prob_vld, 0);
    chk("rst_prob_data", prob_data, 0);
    chk("rst_prob_idx", prob_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    // single row: start at t+2, result all 0x0010 with index 0, start low through the gap
    for (int k = 0; k < NUM; k++) r0[D_W*k +: D_W] = 16'h0100;
    eng_lat = 40;
    push_row(r0);
    @(negedge clk) chk("single_start_t0", sm_start, 0);
    chk("single_busy", busy, 1);
    @(negedge clk) chk("single_start_t1", sm_start, 0);
    @(negedge clk) chk("single_start_t2", sm_start, 1);
    wait_sig("single_vld_wait", 1, 200);
    chk("single_data", prob_data, {NUM{16'h0010}});
    chk("single_idx", prob_idx, 0);
    chk("single_gap0", sm_start, 0);
    @(negedge clk) chk("single_gap1", sm_start, 0);
    @(negedge clk) chk("single_gap2", sm_start, 0);
    wait_out("single_count", 1, 50);
    // burst of 6: FIFO fills after the 5th push (row 0 already popped)
    do_reset();
    eng_lat = 10;
    for (int i = 0; i < 6; i++) begin
      push_row(mk_row(i + 1));
      if (i == 3) chk("burst_rdy_before_full", row_rdy, 1);
      if (i == 4) chk("burst_full", row_rdy, 0);
    end
    wait_out("burst_count", 6, 500);
    chk("burst_last_idx", last_idx, 5);
    // back-pressure: first result held, no new launch until handshake
    do_reset();
    prob_rdy = 1'b0;
    push_row(mk_row(20));
    push_row(mk_row(21));
    wait_sig("bp_vld_wait", 1, 200);
    pd = prob_data;
    pi = prob_idx;
    chk("bp_first_data", pd, xf(mk_row(20)));
    bad = 0;
    starts = 0;
    repeat (100) begin
      @(negedge clk);
      if (prob_data !== pd || prob_idx !== pi || !prob_vld) bad++;
      if (sm_start) starts++;
    end
    chk("bp_hold", bad, 0);
    chk("bp_no_start", starts, 0);
    chk("bp_busy", busy, 1);
    prob_rdy = 1'b1;
    wait_out("bp_count", 2, 300);
    chk("bp_second_idx", last_idx, 1);
    // reset in the middle of S_RUN, then a stray done pulse
    do_reset();
    eng_lat = 40;
    push_row(mk_row(30));
    wait_sig("rst_run_start", 0, 20);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstrun_start", sm_start, 0);
    chk("rstrun_rdy", row_rdy, 1);
    chk("rstrun_busy", busy, 0);
    q_in.delete();
    q_out.delete();
    exp_idx = '0;
    n_out = 0;
    rst = 1'b0;
    late_vld = 1'b1;
    @(negedge clk) late_vld = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (prob_vld) bad++;
    end
    chk("rstrun_late_vld", bad, 0);
    // index wrap over 257 rows
    do_reset();
    eng_lat = 2;
    for (int i = 0; i < 257; i++) push_row(mk_row(i));
    wait_out("wrap_count", 257, 5000);
    chk("wrap_last_idx", last_idx, 0);
`ifdef SOFTMAX_WDOG_EN
    // watchdog: engine silent, error after TIMEOUT cycles in S_RUN, row dropped
    do_reset();
    eng_on = 1'b0;
    push_row(mk_row(40));
    wait_sig("wd_start", 0, 20);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("wd_err_before", err, 0);
    @(negedge clk) chk("wd_err", err, 1);
    chk("wd_start_drop", sm_start, 0);
    repeat (5) @(negedge clk);
    chk("wd_no_out", n_out, 0);
    q_out.delete();
    eng_on = 1'b1;
    eng_lat = 5;
    push_row(mk_row(41));
    wait_out("wd_next_count", 1, 100);
    chk("wd_next_idx", last_idx, 0);
    chk("wd_err_sticky", err, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
